// File: rtl/captura_sequencia_pkg.sv
// Shared definitions for the digit-entry sequencer and the downstream verifier:
// state encoding, default track length, BCD limit and position width.
package captura_sequencia_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'b000,
        AGUARDA   = 3'b001,
        APRESENTA = 3'b010,
        FIM       = 3'b011,
        FALHA     = 3'b100
    } estado_t;

    localparam int N_DIGITOS_DEF = 6;
    localparam int BCD_MAX       = 9;
    localparam int POS_W         = 3;

    function automatic logic eh_bcd(input logic [3:0] d);
        return d <= 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/captura_sequencia_filtro_botao.sv
// filtro_botao: two-flop synchronizer plus debounce for the raw confirm button;
// gives the debounced level and a one-cycle pulse on its rising edge.
module filtro_botao #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic botao_i,
    output logic nivel_o,
    output logic subida_o
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          nivel_q;
    logic          nivel_d;
    logic          nivel_ant_q;
    logic          subida_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronized sample disagrees with the
    // debounced level; any agreeing sample discards the partial count.
    always_comb begin
        cnt_d   = '0;
        nivel_d = nivel_q;
        if (sync2_q != nivel_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                nivel_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            nivel_q     <= 1'b0;
            nivel_ant_q <= 1'b0;
            subida_q    <= 1'b0;
        end else begin
            sync1_q     <= botao_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            nivel_q     <= nivel_d;
            nivel_ant_q <= nivel_q;
            subida_q    <= nivel_q & ~nivel_ant_q;
        end
    end

    assign nivel_o  = nivel_q;
    assign subida_o = subida_q;

endmodule

// File: rtl/captura_sequencia.sv
// Digit-entry sequencer: one BCD digit per debounced confirm press, presented with
// its position as a strobe. Optional entry timeout enabled by macro TIMEOUT_EN.
import captura_sequencia_pkg::*;

module captura_sequencia #(
    parameter int N_DIGITOS  = N_DIGITOS_DEF,
    parameter int DEBOUNCE   = 4,
    parameter int ESPERA_MAX = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    input  logic [3:0]       digito_in,
    input  logic             confirmar,
    input  logic             erro,
    output logic [3:0]       numero,
    output logic [POS_W-1:0] posicao_atual,
    output logic             numero_valido,
    output logic             digito_invalido,
    output logic             sequencia_completa,
    output logic             falha,
    output logic             timeout,
    output logic [2:0]       estado
);

    estado_t          state_q, state_d;
    logic [3:0]       num_q, num_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             valido_q, valido_d;
    logic             invalido_q, invalido_d;
    logic             completa_q, completa_d;
    logic             falha_q, falha_d;
    logic             nivel_botao;
    logic             subida_botao;

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(ESPERA_MAX);
    logic [TW-1:0] timer_q, timer_d;
    logic          tmo_q, tmo_d;
`endif

    filtro_botao #(
        .DEBOUNCE (DEBOUNCE)
    ) u_filtro (
        .clk      (clk),
        .rst      (rst),
        .botao_i  (confirmar),
        .nivel_o  (nivel_botao),
        .subida_o (subida_botao)
    );

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        pos_d      = pos_q;
        valido_d   = 1'b0;
        invalido_d = 1'b0;
`ifdef TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        unique case (state_q)
            OCIOSO: begin
                if (iniciar) begin
                    state_d = AGUARDA;
                    pos_d   = '0;
                end
            end
            AGUARDA: begin
                // A press on the same edge as the timeout takes priority.
                if (subida_botao) begin
                    if (eh_bcd(digito_in)) begin
                        num_d    = digito_in;
                        valido_d = 1'b1;
                        state_d  = APRESENTA;
                    end else begin
                        invalido_d = 1'b1;
                    end
                end
`ifdef TIMEOUT_EN
                else if (timer_q == TW'(ESPERA_MAX - 1)) begin
                    state_d = FALHA;
                    tmo_d   = 1'b1;
                end
`endif
            end
            APRESENTA: begin
                if (erro) begin
                    state_d = FALHA;
                end else if (pos_q == POS_W'(N_DIGITOS - 1)) begin
                    state_d = FIM;
                end else begin
                    pos_d   = pos_q + 1'b1;
                    state_d = AGUARDA;
                end
            end
            FIM, FALHA: begin
                if (iniciar) begin
                    state_d = AGUARDA;
                    pos_d   = '0;
`ifdef TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase
        completa_d = (state_d == FIM);
        falha_d    = (state_d == FALHA);
    end

`ifdef TIMEOUT_EN
    // Restarts on every entry into AGUARDA and on each rejected press.
    always_comb begin
        timer_d = '0;
        if (state_q == AGUARDA && state_d == AGUARDA && !invalido_d) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCIOSO;
            num_q      <= '0;
            pos_q      <= '0;
            valido_q   <= 1'b0;
            invalido_q <= 1'b0;
            completa_q <= 1'b0;
            falha_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            pos_q      <= pos_d;
            valido_q   <= valido_d;
            invalido_q <= invalido_d;
            completa_q <= completa_d;
            falha_q    <= falha_d;
        end
    end

    assign numero             = num_q;
    assign posicao_atual      = pos_q;
    assign numero_valido      = valido_q;
    assign digito_invalido    = invalido_q;
    assign sequencia_completa = completa_q;
    assign falha              = falha_q;
    assign estado             = state_q;

endmodule

// File: tb/tb_captura_sequencia.sv
// Bench for captura_sequencia: directed table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_captura_sequencia;

    localparam int N   = 6;
    localparam int D   = 4;
    localparam int ESP = 20;
`ifdef TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] digito_in = 4'd0;
    logic       confirmar = 1'b0;
    logic       erro = 1'b0;
    logic [3:0] numero;
    logic [2:0] posicao_atual;
    logic       numero_valido;
    logic       digito_invalido;
    logic       sequencia_completa;
    logic       falha;
    logic       timeout;
    logic [2:0] estado;

    captura_sequencia #(
        .N_DIGITOS  (N),
        .DEBOUNCE   (D),
        .ESPERA_MAX (ESP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .iniciar            (iniciar),
        .digito_in          (digito_in),
        .confirmar          (confirmar),
        .erro               (erro),
        .numero             (numero),
        .posicao_atual      (posicao_atual),
        .numero_valido      (numero_valido),
        .digito_invalido    (digito_invalido),
        .sequencia_completa (sequencia_completa),
        .falha              (falha),
        .timeout            (timeout),
        .estado             (estado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int strb_cnt = 0, strb_cyc = 0, strb_num = 0, strb_pos = 0;
    int inv_cnt = 0, inv_cyc = 0;
    always @(negedge clk) begin
        if (numero_valido) begin
            strb_cnt = strb_cnt + 1;
            strb_cyc = cyc;
            strb_num = int'(numero);
            strb_pos = int'(posicao_atual);
        end
        if (digito_invalido) begin
            inv_cnt = inv_cnt + 1;
            inv_cyc = cyc;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: phase, position, last digit, timeout flag, AGUARDA entry edge.
    int m_st, m_pos, m_num, m_tmo, m_a;

    task automatic m_reset();
        m_st = 0; m_pos = 0; m_num = 0; m_tmo = 0; m_a = 0;
    endtask

    task automatic m_advance(input int x);
        if (TMO_EN && m_st == 1 && m_a + ESP <= x) begin
            m_st  = 4;
            m_tmo = 1;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".estado"}, int'(estado), m_st);
        chk({tag, ".posicao"}, int'(posicao_atual), m_pos);
        chk({tag, ".numero"}, int'(numero), m_num);
        chk({tag, ".completa"}, int'(sequencia_completa), int'(m_st == 3));
        chk({tag, ".falha"}, int'(falha), int'(m_st == 4));
        chk({tag, ".timeout"}, int'(timeout), m_tmo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; iniciar = 1'b0; confirmar = 1'b0; erro = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic do_iniciar(output int g);
        @(negedge clk);
        iniciar = 1'b1;
        @(negedge clk);
        g = cyc;
        iniciar = 1'b0;
    endtask

    // Returns t, the first edge that samples confirmar high.
    task automatic press_raw(input int dig, input int hold, input int low, input int er,
                             output int t);
        @(negedge clk);
        confirmar = 1'b1;
        digito_in = 4'(dig);
        erro = er[0];
        t = cyc + 1;
        repeat (hold) @(negedge clk);
        confirmar = 1'b0;
        repeat (low) @(negedge clk);
        erro = 1'b0;
    endtask

    typedef struct {
        int op;        // 0 = iniciar, 1 = press
        int dig;
        int er;
        int exp_st;
        int exp_pos;
        int exp_num;
        int exp_strb;
        int exp_spos;
        int exp_inv;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int t, g, s0, i0, seen;

        tbl[0]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
        tbl[2]  = '{1, 2, 0, 1, 2, 2, 1, 1, 0};
        tbl[3]  = '{1, 3, 0, 1, 3, 3, 1, 2, 0};
        tbl[4]  = '{1, 4, 0, 1, 4, 4, 1, 3, 0};
        tbl[5]  = '{1, 5, 0, 1, 5, 5, 1, 4, 0};
        tbl[6]  = '{1, 6, 0, 3, 5, 6, 1, 5, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 6, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
        tbl[9]  = '{1, 2, 0, 1, 2, 2, 1, 1, 0};
        tbl[10] = '{1, 7, 1, 4, 2, 7, 1, 2, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 7, 0, 0, 0};
        tbl[12] = '{1, 12, 0, 1, 0, 7, 0, 0, 1};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset.outputs",
            int'({numero, posicao_atual, numero_valido, digito_invalido,
                  sequencia_completa, falha, timeout, estado}), 0);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            s0 = strb_cnt; i0 = inv_cnt;
            if (tbl[i].op == 0) do_iniciar(g);
            else press_raw(tbl[i].dig, D + 2, D + 2, tbl[i].er, t);
            chk($sformatf("tbl%0d.estado", i), int'(estado), tbl[i].exp_st);
            chk($sformatf("tbl%0d.posicao", i), int'(posicao_atual), tbl[i].exp_pos);
            chk($sformatf("tbl%0d.numero", i), int'(numero), tbl[i].exp_num);
            chk($sformatf("tbl%0d.strobes", i), strb_cnt - s0, tbl[i].exp_strb);
            chk($sformatf("tbl%0d.invalidos", i), inv_cnt - i0, tbl[i].exp_inv);
            chk($sformatf("tbl%0d.completa", i), int'(sequencia_completa), int'(tbl[i].exp_st == 3));
            chk($sformatf("tbl%0d.falha", i), int'(falha), int'(tbl[i].exp_st == 4));
            chk($sformatf("tbl%0d.timeout", i), int'(timeout), 0);
            if (tbl[i].exp_strb == 1) begin
                chk($sformatf("tbl%0d.strb_num", i), strb_num, tbl[i].dig);
                chk($sformatf("tbl%0d.strb_pos", i), strb_pos, tbl[i].exp_spos);
            end
        end

        // Button held for 50 cycles: one strobe, at the documented latency
        do_reset();
        do_iniciar(g);
        s0 = strb_cnt;
        press_raw(3, 50, D + 2, 0, t);
        chk("held.strobes", strb_cnt - s0, 1);
        chk("held.latency", strb_cyc, t + D + 3);
        chk("held.numero", strb_num, 3);

        // Glitch shorter than the debounce window
        do_reset();
        do_iniciar(g);
        s0 = strb_cnt;
        press_raw(5, 2, D + 4, 0, t);
        chk("glitch.strobes", strb_cnt - s0, 0);
        chk("glitch.estado", int'(estado), 1);

        // Entry timeout
        do_reset();
        do_iniciar(g);
`ifdef TIMEOUT_EN
        repeat (ESP - 1) @(negedge clk);
        chk("tmo.before", int'(estado), 1);
        @(negedge clk);
        chk("tmo.estado", int'(estado), 4);
        chk("tmo.timeout", int'(timeout), 1);
        chk("tmo.falha", int'(falha), 1);
        do_iniciar(g);
        chk("tmo.restart_estado", int'(estado), 1);
        chk("tmo.restart_flags", int'({timeout, falha, posicao_atual}), 0);
`else
        repeat (5 * ESP) @(negedge clk);
        chk("notmo.estado", int'(estado), 1);
        chk("notmo.timeout", int'(timeout), 0);
`endif

        // Reset during APRESENTA
        do_reset();
        do_iniciar(g);
        @(negedge clk);
        confirmar = 1'b1;
        digito_in = 4'd8;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clk);
            if (numero_valido) seen = 1;
        end
        chk("rstap.strobe_seen", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstap.outputs",
            int'({numero, posicao_atual, numero_valido, digito_invalido,
                  sequencia_completa, falha, timeout, estado}), 0);
        rst = 1'b0;
        s0 = strb_cnt;
        repeat (20) @(negedge clk);
        confirmar = 1'b0;
        repeat (D + 4) @(negedge clk);
        chk("rstap.no_strobe", strb_cnt - s0, 0);
        chk("rstap.estado", int'(estado), 0);

        // Randomized transactions against the reference model
        do_reset();
        for (int n = 0; n < 150; n++) begin
            int kind, dig, hold, low, er, e, exp_s, exp_i, sp;
            kind = $urandom_range(0, 99);
            s0 = strb_cnt; i0 = inv_cnt;
            exp_s = 0; exp_i = 0; sp = 0; e = 0;
            if (kind < 15) begin
                do_iniciar(g);
                m_advance(g - 1);
                if (m_st == 0 || m_st == 3 || m_st == 4) begin
                    m_st = 1; m_pos = 0; m_tmo = 0; m_a = g;
                end else begin
                    m_advance(g);
                end
            end else begin
                if (kind < 65) dig = $urandom_range(0, 9);
                else if (kind < 80) dig = $urandom_range(10, 15);
                else dig = $urandom_range(0, 15);
                hold = (kind < 80) ? $urandom_range(D, D + 3) : $urandom_range(1, D - 1);
                low  = $urandom_range(D + 1, D + 3);
                er   = ($urandom_range(0, 3) == 0) ? 1 : 0;
                press_raw(dig, hold, low, er, t);
                if (hold >= D) begin
                    e = t + D + 3;
                    m_advance(e - 1);
                    if (m_st == 1) begin
                        if (dig > 9) begin
                            exp_i = 1;
                            m_a = e;
                        end else begin
                            exp_s = 1;
                            sp = m_pos;
                            m_num = dig;
                            if (er != 0) m_st = 4;
                            else if (m_pos == N - 1) m_st = 3;
                            else begin
                                m_pos = m_pos + 1;
                                m_a = e + 1;
                            end
                        end
                    end
                end
                m_advance(cyc);
            end
            chk_state($sformatf("rnd%0d", n));
            chk($sformatf("rnd%0d.strobes", n), strb_cnt - s0, exp_s);
            chk($sformatf("rnd%0d.invalidos", n), inv_cnt - i0, exp_i);
            if (exp_s == 1) begin
                chk($sformatf("rnd%0d.strb_cyc", n), strb_cyc, e);
                chk($sformatf("rnd%0d.strb_num", n), strb_num, m_num);
                chk($sformatf("rnd%0d.strb_pos", n), strb_pos, sp);
            end
            if (exp_i == 1) begin
                chk($sformatf("rnd%0d.inv_cyc", n), inv_cyc, e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
